axi_burst_initiator: RTL and testbench
======================================

// Module: axi_burst_initiator
// PURPOSE
//  AXI4 master-side transaction engine: the initiator for the slave ports (S0..S6) of the m4s7 NoC.
//  Accepts one command at a time (read or write burst, LEN 0-15).
//  Issues AW/W/B or AR/R handshakes, streams write data in and read data out.
//  Reports a completion status with ID-mismatch, LAST-mismatch and timeout detection.
//  Used as the RTL stimulus master in the NoC integration bench and as a reusable DMA-style front end.
// PARAMETERS
//  ADDR_WIDTH      32    address width (AXI_ADDR_WIDTH)
//  DATA_WIDTH      32    data width; STRB width = DATA_WIDTH/8
//  ID_WIDTH        4     AXI ID width (AXI_SID_WIDTH at slave side, before NoC ID extension)
//  TIMEOUT_CYCLES  1024  max cycles waiting on any single AXI handshake; 0 disables timeout
// PORTS
//  ACLK                    in   1        clock, all logic on posedge
//  ARESETn                 in   1        asynchronous active-low reset
//  cmd_valid/cmd_ready     in/out 1      command handshake
//  cmd_write               in   1        1=write burst, 0=read burst
//  cmd_addr                in   ADDR_W   start address
//  cmd_id                  in   ID_W     transaction ID
//  cmd_len/size/burst      in   4/3/2    AxLEN, AxSIZE, AxBURST, passed unmodified
//  wd_valid/wd_ready       in/out 1      write-data stream handshake
//  wd_data/wd_strb         in   DATA_W/STRB  write beat payload
//  rd_valid/rd_ready       out/in 1      read-data stream handshake
//  rd_data/rd_last         out  DATA_W/1 read beat payload; rd_last = engine's final-beat flag
//  done_valid              out  1        one-cycle completion pulse
//  done_resp               out  2        BRESP, or worst (max) RRESP over the burst
//  done_err                out  3        {timeout, last_mismatch, id_mismatch}
//  M_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  out  AW channel; M_AWREADY in
//  M_W{DATA,STRB,LAST,VALID}           out  W channel;  M_WREADY in
//  M_B{ID,RESP,VALID} in;  M_BREADY out  B channel
//  M_AR{ID,ADDR,LEN,SIZE,BURST,VALID}  out  AR channel; M_ARREADY in
//  M_R{ID,DATA,RESP,LAST,VALID} in; M_RREADY out  R channel
//  Note: LOCK/CACHE/PROT/QOS/REGION/USER are not ports; the integrator ties them to 0.
// BEHAVIOUR
//  Reset: all outputs are 0.
//   - State is IDLE, beat counter 0, timeout counter 0, stored resp 0, stored err 0.
//   - All AXI outputs are registered except the stream pass-throughs below.
//  FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
//  Command acceptance:
//   - cmd_ready = 1 only in IDLE.
//   - On cmd_valid & cmd_ready, latch the command and move to WADDR or RADDR.
//   - Ax*VALID rises the next cycle.
//  WADDR / RADDR:
//   - Hold AxVALID and payload stable until AxREADY.
//   - On the handshake, move to WDATA / RDATA.
//  WDATA:
//   - M_WVALID = wd_valid; wd_ready = M_WREADY; WDATA/WSTRB pass through combinationally.
//   - The beat counter increments per W handshake.
//   - M_WLAST = (count == LEN).
//   - After the last beat, go to WRESP.
//  WRESP:
//   - M_BREADY = 1.
//   - On BVALID, latch BRESP and set id_mismatch if BID != cmd_id.
//   - Then go to DONE.
//  RDATA:
//   - rd_valid = M_RVALID; M_RREADY = rd_ready; data passes through.
//   - rd_last = (count == LEN).
//   - Per beat: resp = max(resp, RRESP); id_mismatch |= (RID != cmd_id); last_mismatch |= (RLAST != (count == LEN)).
//   - Exit to DONE after LEN+1 beats, regardless of RLAST.
//  DONE: done_valid = 1 for exactly one cycle, then IDLE. cmd_ready = 0 during DONE.
//  Timeout counter:
//   - Clears on state entry and on every handshake in the current state.
//   - Increments while waiting in WADDR, WDATA, WRESP, RADDR or RDATA.
//   - At TIMEOUT_CYCLES-1 it sets err[2], drops all VALID/READY next cycle and goes to DONE.
//   - This breaks the protocol and is treated as fatal; the system needs a reset afterwards.
//  Stream stalls (wd_valid=0, or rd_ready=0 with RVALID=1) count toward the timeout.
//  Single outstanding transaction only. W is never issued before AW is accepted.
//  Same-cycle AxVALID & AxREADY counts as the handshake, so AW->W costs one cycle.
//  ARESETn asserted mid-burst: the FSM returns to IDLE immediately and all outputs go to 0.
//   - No done_valid pulse for the aborted command.
// TESTING
//  1. Write LEN=3, AWREADY and WREADY held 1, BRESP=OKAY:
//     -> AWVALID the cycle after acceptance; 4 W beats with WLAST on beat 4.
//     -> done_valid with resp=0, err=0.
//  2. Read LEN=0, ARREADY delayed 5 cycles, RRESP=SLVERR, RID=cmd_id:
//     -> ARVALID held stable for 6 cycles; 1 beat with rd_last=1.
//     -> done_resp=2, err=0.
//  3. Read LEN=7, slave asserts RLAST on beat 6, RRESP=EXOKAY on beat 3:
//     -> 8 beats accepted; err=3'b010; resp=1.
//  4. Write with BID=cmd_id^1 -> err=3'b001, done_resp = the BRESP value.
//  5. TIMEOUT_CYCLES=16, AWREADY held 0:
//     -> AWVALID drops after 16 cycles; done_valid with err=3'b100; cmd_ready=1 the next cycle.
//  6. ARESETn pulsed low during beat 2 of a LEN=15 write:
//     -> all outputs 0 asynchronously; no done_valid; next command is accepted normally.

Source files
------------

// File: rtl/axi_burst_initiator_if.sv
// AXI4 bus bundle between axi_burst_initiator (master) and a slave port.
// Carries the AW, W, B, AR and R channels. LOCK/CACHE/PROT/QOS/REGION/USER
// are not carried; the integrator ties them to 0 on the slave side.
//   master modport : drives AW/W/AR payload + VALID, BREADY, RREADY
//   slave modport  : drives AxREADY, WREADY, B and R payload + VALID
interface axi_burst_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     M_AWID;
  logic [ADDR_WIDTH-1:0]   M_AWADDR;
  logic [3:0]              M_AWLEN;
  logic [2:0]              M_AWSIZE;
  logic [1:0]              M_AWBURST;
  logic                    M_AWVALID;
  logic                    M_AWREADY;

  logic [DATA_WIDTH-1:0]   M_WDATA;
  logic [DATA_WIDTH/8-1:0] M_WSTRB;
  logic                    M_WLAST;
  logic                    M_WVALID;
  logic                    M_WREADY;

  logic [ID_WIDTH-1:0]     M_BID;
  logic [1:0]              M_BRESP;
  logic                    M_BVALID;
  logic                    M_BREADY;

  logic [ID_WIDTH-1:0]     M_ARID;
  logic [ADDR_WIDTH-1:0]   M_ARADDR;
  logic [3:0]              M_ARLEN;
  logic [2:0]              M_ARSIZE;
  logic [1:0]              M_ARBURST;
  logic                    M_ARVALID;
  logic                    M_ARREADY;

  logic [ID_WIDTH-1:0]     M_RID;
  logic [DATA_WIDTH-1:0]   M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RLAST;
  logic                    M_RVALID;
  logic                    M_RREADY;

  modport master (
    output M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
    input  M_AWREADY,
    output M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    input  M_WREADY,
    input  M_BID, M_BRESP, M_BVALID,
    output M_BREADY,
    output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
    input  M_ARREADY,
    input  M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    output M_RREADY
  );

  modport slave (
    input  M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
    output M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    output M_WREADY,
    output M_BID, M_BRESP, M_BVALID,
    input  M_BREADY,
    input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
    output M_ARREADY,
    output M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    input  M_RREADY
  );
endinterface

// File: rtl/axi_burst_initiator.sv
// AXI4 master-side burst engine: one outstanding read or write burst (LEN 0-15).
// Ports:
//   ACLK, ARESETn          clock / asynchronous active-low reset
//   cmd_*                  command handshake and burst descriptor
//   wd_*                   write-data stream in (passed straight to W)
//   rd_*                   read-data stream out (passed straight from R)
//   done_valid/resp/err    one-cycle completion pulse, resp, {timeout, last_mm, id_mm}
//   m                      AXI4 master bus (axi_burst_initiator_if.master)
// Ax*VALID, payloads, BREADY, cmd_ready and done_* are registered; the W and R
// streams are combinational pass-throughs gated by the data-phase state.
module axi_burst_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [3:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic [2:0]              done_err,
  axi_burst_initiator_if.master   m
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [1:0]            resp_q, resp_d;
  logic [2:0]            err_q, err_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  done_valid_q, done_valid_d;
  logic [1:0]            done_resp_q, done_resp_d;
  logic [2:0]            done_err_q, done_err_d;

  logic in_w, in_r, last_beat, hs, waiting;

  assign in_w      = (state_q == S_WDATA);
  assign in_r      = (state_q == S_RDATA);
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    resp_d  = resp_q;
    err_d   = err_q;
    hs      = 1'b0;
    waiting = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          id_d    = cmd_id;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          cnt_d   = '0;
          resp_d  = '0;
          err_d   = '0;
          state_d = cmd_write ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        waiting = 1'b1;
        if (m.M_AWREADY) begin
          hs      = 1'b1;
          state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        waiting = 1'b1;
        if (wd_valid && m.M_WREADY) begin
          hs    = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        waiting = 1'b1;
        if (m.M_BVALID) begin
          hs       = 1'b1;
          resp_d   = m.M_BRESP;
          err_d[0] = (m.M_BID != id_q);
          state_d  = S_DONE;
        end
      end
      S_RADDR: begin
        waiting = 1'b1;
        if (m.M_ARREADY) begin
          hs      = 1'b1;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        waiting = 1'b1;
        if (m.M_RVALID && rd_ready) begin
          hs       = 1'b1;
          resp_d   = (m.M_RRESP > resp_q) ? m.M_RRESP : resp_q;
          err_d[0] = err_q[0] | (m.M_RID != id_q);
          err_d[1] = err_q[1] | (m.M_RLAST != last_beat);
          cnt_d    = cnt_q + 4'd1;
          // Burst length is ours, not the slave's: exit on our count, not RLAST.
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Any handshake restarts the wait; expiry abandons the transaction.
    if (!waiting || hs) begin
      tmo_d = '0;
    end else if (TMO_EN) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d    = '0;
        err_d[2] = 1'b1;
        state_d  = S_DONE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    // Registered outputs are decoded from the next state so they line up with it.
    cmd_ready_d  = (state_d == S_IDLE);
    awvalid_d    = (state_d == S_WADDR);
    arvalid_d    = (state_d == S_RADDR);
    bready_d     = (state_d == S_WRESP);
    done_valid_d = (state_d == S_DONE);
    done_resp_d  = (state_d == S_DONE) ? resp_d : '0;
    done_err_d   = (state_d == S_DONE) ? err_d  : '0;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      id_q         <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      resp_q       <= '0;
      err_q        <= '0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_resp_q  <= '0;
      done_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
      done_err_q   <= done_err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;
  assign done_err   = done_err_q;

  assign m.M_AWID    = id_q;
  assign m.M_AWADDR  = addr_q;
  assign m.M_AWLEN   = len_q;
  assign m.M_AWSIZE  = size_q;
  assign m.M_AWBURST = burst_q;
  assign m.M_AWVALID = awvalid_q;
  assign m.M_ARID    = id_q;
  assign m.M_ARADDR  = addr_q;
  assign m.M_ARLEN   = len_q;
  assign m.M_ARSIZE  = size_q;
  assign m.M_ARBURST = burst_q;
  assign m.M_ARVALID = arvalid_q;
  assign m.M_BREADY  = bready_q;

  assign m.M_WVALID = in_w & wd_valid;
  assign wd_ready   = in_w & m.M_WREADY;
  assign m.M_WDATA  = in_w ? wd_data : '0;
  assign m.M_WSTRB  = in_w ? wd_strb : '0;
  assign m.M_WLAST  = in_w & last_beat;

  assign rd_valid   = in_r & m.M_RVALID;
  assign m.M_RREADY = in_r & rd_ready;
  assign rd_data    = in_r ? m.M_RDATA : '0;
  assign rd_last    = in_r & last_beat;

endmodule

// File: tb/tb_axi_burst_initiator.sv
`timescale 1ns/1ps
module tb_axi_burst_initiator;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int TMO = 16;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [IW-1:0] cmd_id;
  logic [3:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [DW/8-1:0] wd_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done_valid;
  logic [1:0]    done_resp;
  logic [2:0]    done_err;

  axi_burst_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_burst_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .m(bus)
  );

  int checks = 0;
  int errors = 0;

  // Per-transaction stimulus / slave behaviour tables.
  logic [DW-1:0]   t_wdata [16];
  logic [DW/8-1:0] t_wstrb [16];
  logic [DW-1:0]   t_rdata [16];
  logic [1:0]      t_rresp [16];
  logic [IW-1:0]   t_rid   [16];
  logic            t_rlast [16];
  logic [1:0]      t_bresp;
  logic [IW-1:0]   t_bid;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] all_outs();
    return 256'({cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done_valid, done_resp, done_err,
                 bus.M_AWID, bus.M_AWADDR, bus.M_AWLEN, bus.M_AWSIZE, bus.M_AWBURST, bus.M_AWVALID,
                 bus.M_WDATA, bus.M_WSTRB, bus.M_WLAST, bus.M_WVALID, bus.M_BREADY,
                 bus.M_ARID, bus.M_ARADDR, bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST, bus.M_ARVALID,
                 bus.M_RREADY});
  endfunction

  // Reference completion: {err[2:0], resp[1:0]} from the burst's slave responses.
  function automatic logic [4:0] expect_done(input bit wr, input logic [IW-1:0] id, input int unsigned len);
    logic [1:0] r;
    bit im, lm;
    r = '0; im = 1'b0; lm = 1'b0;
    if (wr) return {1'b0, 1'b0, (t_bid != id), t_bresp};
    for (int unsigned i = 0; i <= len; i++) begin
      if (t_rresp[i] > r) r = t_rresp[i];
      if (t_rid[i] != id) im = 1'b1;
      if (t_rlast[i] != (i == len)) lm = 1'b1;
    end
    return {1'b0, lm, im, r};
  endfunction

  task automatic drive_idle();
    wd_valid = '0; wd_data = '0; wd_strb = '0; rd_ready = '0;
    bus.M_AWREADY = '0; bus.M_WREADY = '0;
    bus.M_BID = '0; bus.M_BRESP = '0; bus.M_BVALID = '0;
    bus.M_ARREADY = '0;
    bus.M_RID = '0; bus.M_RDATA = '0; bus.M_RRESP = '0; bus.M_RLAST = '0; bus.M_RVALID = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    cmd_valid = '0;
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("reset_outputs_zero", all_outs(), '0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    #4;
    chk("cmd_ready_after_reset", 256'(cmd_ready), 256'(1'b1));
  endtask

  task automatic fill_random(input logic [IW-1:0] id, input int unsigned len);
    for (int unsigned i = 0; i < 16; i++) begin
      t_wdata[i] = $urandom;
      t_wstrb[i] = 4'($urandom);
      t_rdata[i] = $urandom;
      t_rresp[i] = 2'($urandom);
      t_rid[i]   = ($urandom_range(0, 9) == 0) ? (id ^ 4'h2) : id;
      t_rlast[i] = (i == len) ^ ($urandom_range(0, 9) == 0);
    end
    t_bresp = 2'($urandom);
    t_bid   = ($urandom_range(0, 4) == 0) ? ~id : id;
  endtask

  // One command from acceptance to the cycle after done. Phases: 0 command,
  // 1 address, 2 data beats, 3 write response, 4 expect done, 5 expect idle.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                         input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input int unsigned addr_delay, input bit stalls, input bit exp_tmo,
                         input int abort_beat);
    int phase = 0;
    int unsigned L = 32'(len);
    int unsigned beat = 0, addr_wait = 0, stall = 0, b_wait = 0;
    int unsigned b_delay = stalls ? $urandom_range(0, 3) : 0;
    bit rdy_drv, v, r, fin = 1'b0, seen;
    logic axv;
    logic [4:0] exp = expect_done(wr, id, L);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge ACLK);
      drive_idle();
      cmd_valid = '0;
      rdy_drv = 1'b0;
      case (phase)
        0: begin
          cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_id = id;
          cmd_len = len; cmd_size = size; cmd_burst = burst;
        end
        1: if (addr_wait >= addr_delay) begin
          rdy_drv = 1'b1;
          if (wr) bus.M_AWREADY = 1'b1; else bus.M_ARREADY = 1'b1;
        end
        2: begin
          v = 1'b1; r = 1'b1;
          if (stalls && stall < 3) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
          end
          if (wr) begin
            wd_valid = v; bus.M_WREADY = r;
            wd_data = t_wdata[beat[3:0]]; wd_strb = t_wstrb[beat[3:0]];
          end else begin
            bus.M_RVALID = v; rd_ready = r;
            bus.M_RDATA = t_rdata[beat[3:0]]; bus.M_RID = t_rid[beat[3:0]];
            bus.M_RRESP = t_rresp[beat[3:0]]; bus.M_RLAST = t_rlast[beat[3:0]];
          end
          if (abort_beat >= 0 && beat == abort_beat) begin
            ARESETn = 1'b0;
            #1;
            chk("async_reset_outputs_zero", all_outs(), '0);
            seen = 1'b0;
            repeat (2) begin @(negedge ACLK); if (done_valid) seen = 1'b1; end
            ARESETn = 1'b1;
            drive_idle();
            repeat (3) begin @(negedge ACLK); #4; if (done_valid) seen = 1'b1; end
            chk("no_done_after_abort", 256'(seen), 256'(1'b0));
            return;
          end
        end
        3: if (b_wait >= b_delay) begin
          bus.M_BVALID = 1'b1; bus.M_BID = t_bid; bus.M_BRESP = t_bresp;
        end
        default: ;
      endcase
      #4;
      case (phase)
        0: if (cmd_ready) phase = 1;
        1: begin
          axv = wr ? bus.M_AWVALID : bus.M_ARVALID;
          if (exp_tmo) begin
            if (axv) addr_wait++;
            else begin
              chk("timeout_valid_cycles", 256'(addr_wait), 256'(TMO));
              chk("timeout_done", 256'({done_valid, done_err, done_resp}), 256'({1'b1, 3'b100, 2'b00}));
              phase = 5;
            end
          end else begin
            if (wr) chk("aw_channel", 256'({bus.M_AWVALID, bus.M_ARVALID, bus.M_AWID, bus.M_AWADDR,
                                            bus.M_AWLEN, bus.M_AWSIZE, bus.M_AWBURST, bus.M_WVALID}),
                        256'({1'b1, 1'b0, id, addr, len, size, burst, 1'b0}));
            else    chk("ar_channel", 256'({bus.M_ARVALID, bus.M_AWVALID, bus.M_ARID, bus.M_ARADDR,
                                            bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST, rd_valid}),
                        256'({1'b1, 1'b0, id, addr, len, size, burst, 1'b0}));
            addr_wait++;
            if (rdy_drv) begin
              chk("ax_hold_cycles", 256'(addr_wait), 256'(addr_delay + 1));
              phase = 2;
            end
          end
        end
        2: begin
          if (wr) begin
            chk("w_beat", 256'({bus.M_WVALID, wd_ready, bus.M_WDATA, bus.M_WSTRB, bus.M_WLAST, done_valid}),
                256'({wd_valid, bus.M_WREADY, t_wdata[beat[3:0]], t_wstrb[beat[3:0]], (beat == L), 1'b0}));
            v = wd_valid && bus.M_WREADY;
          end else begin
            chk("r_beat", 256'({rd_valid, bus.M_RREADY, rd_data, rd_last, done_valid}),
                256'({bus.M_RVALID, rd_ready, t_rdata[beat[3:0]], (beat == L), 1'b0}));
            v = bus.M_RVALID && rd_ready;
          end
          if (v) begin
            beat++; stall = 0;
            if (beat > L) phase = wr ? 3 : 4;
          end else stall++;
        end
        3: begin
          chk("b_ready", 256'({bus.M_BREADY, done_valid}), 256'(2'b10));
          b_wait++;
          if (bus.M_BVALID) phase = 4;
        end
        4: begin
          chk("done", 256'({done_valid, done_err, done_resp}), 256'({1'b1, exp}));
          phase = 5;
        end
        default: begin
          chk("idle_after_done", 256'({cmd_ready, done_valid}), 256'(2'b10));
          fin = 1'b1;
        end
      endcase
    end
    chk("txn_complete", 256'(fin), 256'(1'b1));
  endtask

  initial begin
    logic [IW-1:0] id;
    logic [3:0] len;
    cmd_valid = '0; cmd_write = '0; cmd_addr = '0; cmd_id = '0;
    cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    drive_idle();
    do_reset();

    // Write LEN=3, no backpressure, OKAY.
    fill_random(4'h3, 3);
    t_bresp = 2'b00; t_bid = 4'h3;
    run_txn(1'b1, 32'h1000_0040, 4'h3, 4'd3, 3'd2, 2'b01, 0, 1'b0, 1'b0, -1);

    // Read LEN=0, ARREADY after 5 cycles, SLVERR.
    fill_random(4'h5, 0);
    t_rresp[0] = 2'b10; t_rid[0] = 4'h5; t_rlast[0] = 1'b1;
    run_txn(1'b0, 32'h2000_0000, 4'h5, 4'd0, 3'd2, 2'b01, 5, 1'b0, 1'b0, -1);

    // Read LEN=7, RLAST early on beat 6, EXOKAY on beat 3.
    fill_random(4'h9, 7);
    for (int i = 0; i < 16; i++) begin t_rresp[i] = 2'b00; t_rid[i] = 4'h9; t_rlast[i] = 1'b0; end
    t_rresp[2] = 2'b01; t_rlast[5] = 1'b1;
    run_txn(1'b0, 32'h3000_0100, 4'h9, 4'd7, 3'd2, 2'b01, 1, 1'b1, 1'b0, -1);

    // Write with wrong BID.
    fill_random(4'hA, 2);
    t_bid = 4'hA ^ 4'h1; t_bresp = 2'b10;
    run_txn(1'b1, 32'h4000_0000, 4'hA, 4'd2, 3'd2, 2'b01, 2, 1'b1, 1'b0, -1);

    // AWREADY never comes: timeout, then reset to recover.
    fill_random(4'h1, 0);
    run_txn(1'b1, 32'h5000_0000, 4'h1, 4'd0, 3'd2, 2'b01, 1000, 1'b0, 1'b1, -1);
    do_reset();

    // Reset during beat 2 of a LEN=15 write, then a normal command.
    fill_random(4'h6, 15);
    run_txn(1'b1, 32'h6000_0000, 4'h6, 4'd15, 3'd2, 2'b01, 0, 1'b0, 1'b0, 1);
    fill_random(4'h7, 1);
    run_txn(1'b1, 32'h7000_0000, 4'h7, 4'd1, 3'd2, 2'b01, 0, 1'b0, 1'b0, -1);

    // Randomized bursts.
    for (int n = 0; n < 24; n++) begin
      id  = 4'($urandom);
      len = 4'($urandom);
      fill_random(id, 32'(len));
      run_txn(1'($urandom), $urandom, id, len, 3'($urandom), 2'($urandom),
              $urandom_range(0, 4), 1'b1, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
